// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: turns the receiver's level-held
// ready/error flags into single events, queues good bytes and counts errored frames.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_ready,
    input  logic          rx_error,
    input  logic [7:0]    rx_val,
    input  logic          rd_en,
    input  logic          clr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    err_count
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW - 1){1'b0}}, 1'b1};

    logic [7:0]    mem [DEPTH];

    logic          readyPrev_q;
    logic          errorPrev_q;
    logic [AW-1:0] wrPtr_q,    wrPtr_d;
    logic [AW-1:0] rdPtr_q,    rdPtr_d;
    logic [AW:0]   count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    errCount_q, errCount_d;
    logic          rdValid_q,  rdValid_d;
    logic [7:0]    rdData_q;

    logic writeEvent;
    logic errorEvent;
    logic rdAccept;
    logic wrAccept;
    logic wrDrop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    assign writeEvent = rx_ready & ~readyPrev_q;
    assign errorEvent = rx_error & ~errorPrev_q;

    // A full FIFO can still take a byte when a read frees the oldest slot in the same cycle.
    assign rdAccept = rd_en & ~empty & ~clr;
    assign wrAccept = writeEvent & (~full | rdAccept) & ~clr;
    assign wrDrop   = writeEvent & full & ~rdAccept & ~clr;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        errCount_d = errCount_q;
        rdValid_d  = 1'b0;

        if (clr) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            errCount_d = 8'd0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (rdAccept) begin
                rdPtr_d   = rdPtr_q + PTR_ONE;
                rdValid_d = 1'b1;
            end
            case ({wrAccept, rdAccept})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
            if (wrDrop) begin
                overflow_d = 1'b1;
            end
            if (errorEvent && errCount_q != 8'hFF) begin
                errCount_d = errCount_q + 8'd1;
            end
        end
    end

    // Edge-detect history resets high so a level already present at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            readyPrev_q <= 1'b1;
            errorPrev_q <= 1'b1;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            errCount_q  <= 8'd0;
            rdValid_q   <= 1'b0;
        end else begin
            readyPrev_q <= rx_ready;
            errorPrev_q <= rx_error;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            errCount_q  <= errCount_d;
            rdValid_q   <= rdValid_d;
        end
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wrAccept && !rst) begin
            mem[wrPtr_q] <= rx_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= 8'd0;
        end else if (rdAccept) begin
            rdData_q <= mem[rdPtr_q];
        end
    end

    assign rd_data   = rdData_q;
    assign rd_valid  = rdValid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: each scenario task drives the receiver-side
// level signals and the read port, then compares outputs against hand-derived values.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_ready;
    logic       rx_error;
    logic [7:0] rx_val;
    logic       rd_en;
    logic       clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_error  (rx_error),
        .rx_val    (rx_val),
        .rd_en     (rd_en),
        .clr       (clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] val);
        rx_val   = val;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_ready = 1'b1; rx_error = 1'b1; rx_val = 8'h3C;
        rd_en = 1'b0; clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (count !== 5'd0) begin
            errors++; $display("[TB] FAIL reset_count actual=%0d expected=0", count);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags empty=%b full=%b expected empty=1 full=0", empty, full);
        end
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rd rd_data=%h rd_valid=%b expected 00/0", rd_data, rd_valid);
        end
        checks++;
        if (overflow !== 1'b0 || err_count !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_status overflow=%b err_count=%0d expected 0/0", overflow, err_count);
        end
        rx_ready = 1'b0; rx_error = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        int maxCount = 0;
        rx_val = 8'hA5; rx_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (int'(count) > maxCount) maxCount = int'(count);
        end
        rx_ready = 1'b0;
        tick();
        checks++;
        if (maxCount !== 1 || count !== 5'd1) begin
            errors++; $display("[TB] FAIL single_count max=%0d now=%0d expected 1/1", maxCount, count);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'hA5 || rd_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL single_read rd_data=%h rd_valid=%b expected a5/1", rd_data, rd_valid);
        end
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++; $display("[TB] FAIL single_empty empty=%b count=%0d expected 1/0", empty, count);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_pulse rd_valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) sendByte(8'(i));
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL fill_full full=%b count=%0d overflow=%b expected 1/16/0", full, count, overflow);
        end
        sendByte(8'hFF);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++; $display("[TB] FAIL fill_overflow overflow=%b count=%0d expected 1/16", overflow, count);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL fill_order[%0d] rd_data=%h rd_valid=%b expected %h/1", i, rd_data, rd_valid, 8'(i));
            end
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h0F) begin
            errors++; $display("[TB] FAIL fill_drained empty=%b rd_valid=%b rd_data=%h expected 1/0/0f", empty, rd_valid, rd_data);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("[TB] FAIL overflow_sticky actual=%b expected 1", overflow);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL overflow_clr actual=%b expected 0", overflow);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) sendByte(8'h10 + 8'(i));
        rx_val = 8'h55; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || rd_data !== 8'h10) begin
            errors++; $display("[TB] FAIL full_simul count=%0d overflow=%b rd_data=%h expected 16/0/10", count, overflow, rd_data);
        end
        tick();
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (rd_data !== ((i == 16) ? 8'h55 : 8'h10 + 8'(i))) begin
                errors++; $display("[TB] FAIL full_simul_order[%0d] rd_data=%h expected %h", i, rd_data,
                                   (i == 16) ? 8'h55 : 8'h10 + 8'(i));
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("[TB] FAIL full_simul_empty empty=%b expected 1", empty);
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 3; i++) begin
            rx_error = 1'b1; tick(); rx_error = 1'b0; tick();
        end
        checks++;
        if (err_count !== 8'd3 || count !== 5'd0) begin
            errors++; $display("[TB] FAIL err_three err_count=%0d count=%0d expected 3/0", err_count, count);
        end
        for (int i = 0; i < 300; i++) begin
            rx_error = 1'b1; tick(); rx_error = 1'b0; tick();
        end
        checks++;
        if (err_count !== 8'd255 || count !== 5'd0) begin
            errors++; $display("[TB] FAIL err_saturate err_count=%0d count=%0d expected 255/0", err_count, count);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (err_count !== 8'd0) begin
            errors++; $display("[TB] FAIL err_clr err_count=%0d expected 0", err_count);
        end
    endtask

    task automatic test_wrap();
        int maxCount = 0;
        for (int i = 0; i < 40; i++) begin
            rx_val = 8'(i); rx_ready = 1'b1; rd_en = (i >= 3);
            tick();
            if (i >= 3) begin
                checks++;
                if (rd_data !== 8'(i - 3) || rd_valid !== 1'b1) begin
                    errors++; $display("[TB] FAIL wrap_order[%0d] rd_data=%h rd_valid=%b expected %h/1", i, rd_data, rd_valid, 8'(i - 3));
                end
            end
            if (int'(count) > maxCount) maxCount = int'(count);
            rx_ready = 1'b0; rd_en = 1'b0;
            tick();
        end
        rd_en = 1'b1;
        for (int i = 37; i < 40; i++) begin
            tick();
            checks++;
            if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin
                errors++; $display("[TB] FAIL wrap_drain[%0d] rd_data=%h rd_valid=%b expected %h/1", i, rd_data, rd_valid, 8'(i));
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (empty !== 1'b1 || maxCount > 5) begin
            errors++; $display("[TB] FAIL wrap_end empty=%b maxCount=%0d expected 1/<=5", empty, maxCount);
        end
    endtask

    task automatic test_empty_simul();
        rx_val = 8'h77; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd1 || rd_data !== 8'd39) begin
            errors++; $display("[TB] FAIL empty_simul rd_valid=%b count=%0d rd_data=%h expected 0/1/27", rd_valid, count, rd_data);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'h77 || rd_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL empty_simul_read rd_data=%h rd_valid=%b expected 77/1", rd_data, rd_valid);
        end
        tick();
    endtask

    task automatic test_clear();
        sendByte(8'hC1);
        sendByte(8'hC2);
        rx_error = 1'b1; tick(); rx_error = 1'b0; tick();
        rx_val = 8'hC3; rx_ready = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        rx_ready = 1'b0;
        tick();
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || err_count !== 8'd0) begin
            errors++; $display("[TB] FAIL clr_state count=%0d empty=%b err_count=%0d expected 0/1/0", count, empty, err_count);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h77) begin
            errors++; $display("[TB] FAIL clr_no_stale rd_valid=%b rd_data=%h expected 0/77", rd_valid, rd_data);
        end
        sendByte(8'hD4);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'hD4 || rd_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL clr_resume rd_data=%h rd_valid=%b expected d4/1", rd_data, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_full_simul();
        test_errors();
        test_wrap();
        test_empty_simul();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
